// File: rtl/uart_arith_ctrl_if.sv
// Handshake bundle between the UART/arith command sequencer and its neighbours.
// master: the sequencer; slave: uart_rx/uart_tx/arithmetic core side.
interface uart_arith_ctrl_if #(
    parameter int OPW = 32
);
    logic [7:0]       iRxByte;
    logic             iRxDone;
    logic             oTxStart;
    logic [7:0]       oTxByte;
    logic             iTxBusy;
    logic             iTxDone;
    logic             oOpStart;
    logic [1:0]       oOpCode;
    logic [OPW-1:0]   oOperandA;
    logic [OPW-1:0]   oOperandB;
    logic             iOpDone;
    logic [2*OPW-1:0] iResult;
    logic             iOpErr;
    logic             oBusy;
    logic             oOverrun;

    modport master (
        input  iRxByte, iRxDone, iTxBusy, iTxDone, iOpDone, iResult, iOpErr,
        output oTxStart, oTxByte, oOpStart, oOpCode, oOperandA, oOperandB,
               oBusy, oOverrun
    );

    modport slave (
        output iRxByte, iRxDone, iTxBusy, iTxDone, iOpDone, iResult, iOpErr,
        input  oTxStart, oTxByte, oOpStart, oOpCode, oOperandA, oOperandB,
               oBusy, oOverrun
    );
endinterface

// File: rtl/uart_arith_ctrl.sv
// Command sequencer: collects opcode + two operands from uart_rx, runs one
// arithmetic operation, and returns status (+ result, MSB first) via uart_tx.
//
// state     | meaning
// IDLE      | waiting for an opcode byte
// RX_A      | shifting in operand A bytes
// RX_B      | shifting in operand B bytes, then validate opcode
// EXEC      | launch the arithmetic core
// WAIT      | waiting for the core to finish
// TX_LOAD   | start the current response byte once uart_tx is free
// TX_WAIT   | waiting for uart_tx to finish the byte
module uart_arith_ctrl #(
    parameter int OPW            = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  iClk,
    input  logic                  iRst,
    uart_arith_ctrl_if.master     bus
);

    localparam int NB_OP  = OPW / 8;
    localparam int NB_RES = 2 * OPW / 8;
    localparam int CW     = $clog2(NB_RES + 1);
    localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] OP_LAST  = CW'(NB_OP - 1);
    localparam logic [CW-1:0] RES_LAST = CW'(NB_RES);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] ST_OK    = 8'h00;
    localparam logic [7:0] ST_OPERR = 8'hE1;
    localparam logic [7:0] ST_BADOP = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_A,
        S_RX_B,
        S_EXEC,
        S_WAIT,
        S_TX_LOAD,
        S_TX_WAIT
    } state_t;

    state_t           state_q,    state_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [TW-1:0]    tmr_q,      tmr_d;
    logic [7:0]       opc_q,      opc_d;
    logic [OPW-1:0]   a_sh_q,     a_sh_d;
    logic [OPW-1:0]   b_sh_q,     b_sh_d;
    logic [OPW-1:0]   op_a_q,     op_a_d;
    logic [OPW-1:0]   op_b_q,     op_b_d;
    logic [1:0]       op_code_q,  op_code_d;
    logic [2*OPW-1:0] res_q,      res_d;
    logic [7:0]       status_q,   status_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_byte_q,  tx_byte_d;
    logic             op_start_q, op_start_d;
    logic             overrun_q,  overrun_d;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tmr_q      <= '0;
            opc_q      <= '0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_code_q  <= '0;
            res_q      <= '0;
            status_q   <= '0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
            op_start_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            opc_q      <= opc_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_code_q  <= op_code_d;
            res_q      <= res_d;
            status_q   <= status_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
            op_start_q <= op_start_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        opc_d      = opc_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_code_d  = op_code_q;
        res_d      = res_q;
        status_d   = status_q;
        tx_start_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        op_start_d = 1'b0;
        overrun_d  = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (bus.iRxDone) begin
                    opc_d   = bus.iRxByte;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    state_d = S_RX_A;
                end
            end

            S_RX_A: begin
                if (bus.iRxDone) begin
                    a_sh_d = (a_sh_q << 8) | OPW'(bus.iRxByte);
                    tmr_d  = '0;
                    if (cnt_q == OP_LAST) begin
                        cnt_d   = '0;
                        state_d = S_RX_B;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (tmr_q == TMR_LAST) begin
                    tmr_d   = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end

            S_RX_B: begin
                if (bus.iRxDone) begin
                    b_sh_d = (b_sh_q << 8) | OPW'(bus.iRxByte);
                    tmr_d  = '0;
                    if (cnt_q == OP_LAST) begin
                        cnt_d = '0;
                        // Only opcodes 0x00..0x03 reach the core.
                        if (opc_q[7:2] == 6'd0) begin
                            state_d = S_EXEC;
                        end else begin
                            status_d = ST_BADOP;
                            state_d  = S_TX_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (tmr_q == TMR_LAST) begin
                    tmr_d   = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end

            S_EXEC: begin
                op_start_d = 1'b1;
                op_a_d     = a_sh_q;
                op_b_d     = b_sh_q;
                op_code_d  = opc_q[1:0];
                state_d    = S_WAIT;
            end

            S_WAIT: begin
                if (bus.iOpDone) begin
                    res_d    = bus.iResult;
                    status_d = bus.iOpErr ? ST_OPERR : ST_OK;
                    cnt_d    = '0;
                    state_d  = S_TX_LOAD;
                end
            end

            S_TX_LOAD: begin
                if (!bus.iTxBusy) begin
                    tx_start_d = 1'b1;
                    state_d    = S_TX_WAIT;
                    if (cnt_q == '0) begin
                        tx_byte_d = status_q;
                    end else begin
                        tx_byte_d = res_q[2*OPW-1 -: 8];
                        res_d     = res_q << 8;
                    end
                end
            end

            S_TX_WAIT: begin
                if (bus.iTxDone) begin
                    if ((status_q == ST_OK) && (cnt_q != RES_LAST)) begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = S_TX_LOAD;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Bytes arriving while an operation or response is in flight are lost.
        if (bus.iRxDone && (state_q inside {S_EXEC, S_WAIT, S_TX_LOAD, S_TX_WAIT})) begin
            overrun_d = 1'b1;
        end
    end

    assign bus.oTxStart  = tx_start_q;
    assign bus.oTxByte   = tx_byte_q;
    assign bus.oOpStart  = op_start_q;
    assign bus.oOpCode   = op_code_q;
    assign bus.oOperandA = op_a_q;
    assign bus.oOperandB = op_b_q;
    assign bus.oBusy     = (state_q != S_IDLE);
    assign bus.oOverrun  = overrun_q;

endmodule

// File: tb/tb_uart_arith_ctrl.sv
// Scoreboard bench for uart_arith_ctrl with behavioural arithmetic core and uart_tx.
module tb_uart_arith_ctrl;
    localparam int OPW = 16;
    localparam int TMO = 200;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [7:0]  exp_tx[$];
    logic [7:0]  obs_tx[$];
    logic [33:0] exp_op[$];
    logic [33:0] obs_op[$];
    int op_consec = 0;
    int tx_consec = 0;
    int hold_viol = 0;

    uart_arith_ctrl_if #(.OPW(OPW)) bus ();

    uart_arith_ctrl #(.OPW(OPW), .TIMEOUT_CYCLES(TMO)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] arith(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [31:0] xa, xb;
        xa = {16'h0, a};
        xb = {16'h0, b};
        case (op)
            2'd0:    return {1'b0, xa + xb};
            2'd1:    return {1'b0, xa - xb};
            2'd2:    return {1'b0, xa * xb};
            default: return (b == 16'h0) ? {1'b1, 32'h0} : {1'b0, xa / xb};
        endcase
    endfunction

    // Arithmetic core model: fixed 6-cycle latency.
    int          core_cnt = 0;
    logic [32:0] core_r;
    logic        prev_op = 1'b0;
    always @(negedge clk) begin
        bus.iOpDone = 1'b0;
        if (rst) begin
            core_cnt     = 0;
            bus.iResult  = '0;
            bus.iOpErr   = 1'b0;
            prev_op      = 1'b0;
        end else begin
            if (bus.oOpStart && prev_op) op_consec++;
            prev_op = bus.oOpStart;
            if (bus.oOpStart) begin
                obs_op.push_back({bus.oOpCode, bus.oOperandA, bus.oOperandB});
                core_r   = arith(bus.oOpCode, bus.oOperandA, bus.oOperandB);
                core_cnt = 6;
            end else if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    bus.iOpDone = 1'b1;
                    bus.iResult = core_r[31:0];
                    bus.iOpErr  = core_r[32];
                end
            end
        end
    end

    // uart_tx model: busy for 4 cycles per byte, checks the byte is held.
    int         tx_cnt = 0;
    logic [7:0] tx_hold;
    logic       prev_tx = 1'b0;
    always @(negedge clk) begin
        bus.iTxDone = 1'b0;
        if (rst) begin
            tx_cnt      = 0;
            bus.iTxBusy = 1'b0;
            prev_tx     = 1'b0;
        end else begin
            if (bus.oTxStart && prev_tx) tx_consec++;
            prev_tx = bus.oTxStart;
            if (bus.oTxStart) begin
                obs_tx.push_back(bus.oTxByte);
                tx_hold     = bus.oTxByte;
                tx_cnt      = 4;
                bus.iTxBusy = 1'b1;
            end else if (tx_cnt > 0) begin
                if (bus.oTxByte !== tx_hold) hold_viol++;
                tx_cnt--;
                if (tx_cnt == 0) begin
                    bus.iTxDone = 1'b1;
                    bus.iTxBusy = 1'b0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.iRxByte = b;
        bus.iRxDone = 1'b1;
        @(negedge clk);
        bus.iRxDone = 1'b0;
    endtask

    task automatic push_expected(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [32:0] r;
        if (op > 8'h03) begin
            exp_tx.push_back(8'hEE);
        end else begin
            exp_op.push_back({op[1:0], a, b});
            r = arith(op[1:0], a, b);
            if (r[32]) begin
                exp_tx.push_back(8'hE1);
            end else begin
                exp_tx.push_back(8'h00);
                exp_tx.push_back(r[31:24]);
                exp_tx.push_back(r[23:16]);
                exp_tx.push_back(r[15:8]);
                exp_tx.push_back(r[7:0]);
            end
        end
    endtask

    task automatic send_packet(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        push_expected(op, a, b);
        send_byte(op);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(b[15:8]);
        send_byte(b[7:0]);
    endtask

    task automatic wait_idle(output bit ok);
        int k;
        k = 0;
        while (bus.oBusy !== 1'b0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        ok = (bus.oBusy === 1'b0);
    endtask

    task automatic test_reset;
        rst         = 1'b1;
        bus.iRxDone = 1'b0;
        bus.iRxByte = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus.oTxStart, bus.oTxByte, bus.oOpStart, bus.oOpCode, bus.oOperandA,
             bus.oOperandB, bus.oBusy, bus.oOverrun} !== 46'h0)
            $display("FAIL reset_outputs: got %h want 0", {bus.oTxStart, bus.oTxByte,
                     bus.oOpStart, bus.oOpCode, bus.oOperandA, bus.oOperandB, bus.oBusy, bus.oOverrun});
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_add;
        bit ok;
        logic [7:0] e8, o8;
        logic [33:0] e34, o34;
        push_expected(8'h00, 16'h1234, 16'h0011);
        send_byte(8'h00);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h00);
        @(negedge clk);
        bus.iRxByte = 8'h11;
        bus.iRxDone = 1'b1;
        @(negedge clk);
        bus.iRxDone = 1'b0;
        n_checks++;
        if (bus.oOpStart !== 1'b0) $display("FAIL add op_start_early: got %b want 0", bus.oOpStart);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({bus.oOpStart, bus.oOpCode, bus.oOperandA, bus.oOperandB} !== {1'b1, 2'd0, 16'h1234, 16'h0011})
            $display("FAIL add op_launch: got %b %h %h %h want 1 0 1234 0011",
                     bus.oOpStart, bus.oOpCode, bus.oOperandA, bus.oOperandB);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.oOpStart !== 1'b0) $display("FAIL add op_start_width: got %b want 0", bus.oOpStart);
        else n_pass++;
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("FAIL add idle_timeout: got busy want idle"); else n_pass++;
        n_checks++;
        if (obs_tx.size() != exp_tx.size())
            $display("FAIL add tx_count: got %0d want %0d", obs_tx.size(), exp_tx.size());
        else n_pass++;
        while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
            e8 = exp_tx.pop_front(); o8 = obs_tx.pop_front(); n_checks++;
            if (o8 !== e8) $display("FAIL add tx_byte: got %h want %h", o8, e8); else n_pass++;
        end
        n_checks++;
        if (obs_op.size() != exp_op.size())
            $display("FAIL add op_count: got %0d want %0d", obs_op.size(), exp_op.size());
        else n_pass++;
        while (exp_op.size() > 0 && obs_op.size() > 0) begin
            e34 = exp_op.pop_front(); o34 = obs_op.pop_front(); n_checks++;
            if (o34 !== e34) $display("FAIL add op_record: got %h want %h", o34, e34); else n_pass++;
        end
        exp_tx.delete(); obs_tx.delete(); exp_op.delete(); obs_op.delete();
    endtask

    task automatic test_div_zero;
        bit ok;
        logic [7:0] e8, o8;
        send_packet(8'h03, 16'h0008, 16'h0000);
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("FAIL div0 idle_timeout: got busy want idle"); else n_pass++;
        n_checks++;
        if (obs_tx.size() != exp_tx.size())
            $display("FAIL div0 tx_count: got %0d want %0d", obs_tx.size(), exp_tx.size());
        else n_pass++;
        while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
            e8 = exp_tx.pop_front(); o8 = obs_tx.pop_front(); n_checks++;
            if (o8 !== e8) $display("FAIL div0 tx_byte: got %h want %h", o8, e8); else n_pass++;
        end
        n_checks++;
        if (obs_op.size() != exp_op.size())
            $display("FAIL div0 op_count: got %0d want %0d", obs_op.size(), exp_op.size());
        else n_pass++;
        exp_tx.delete(); obs_tx.delete(); exp_op.delete(); obs_op.delete();
    endtask

    task automatic test_bad_opcode;
        bit ok;
        logic [7:0] e8, o8;
        send_packet(8'h07, 16'hAABB, 16'hCCDD);
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("FAIL badop idle_timeout: got busy want idle"); else n_pass++;
        n_checks++;
        if (obs_op.size() != exp_op.size())
            $display("FAIL badop op_count: got %0d want %0d", obs_op.size(), exp_op.size());
        else n_pass++;
        n_checks++;
        if (obs_tx.size() != exp_tx.size())
            $display("FAIL badop tx_count: got %0d want %0d", obs_tx.size(), exp_tx.size());
        else n_pass++;
        while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
            e8 = exp_tx.pop_front(); o8 = obs_tx.pop_front(); n_checks++;
            if (o8 !== e8) $display("FAIL badop tx_byte: got %h want %h", o8, e8); else n_pass++;
        end
        exp_tx.delete(); obs_tx.delete(); exp_op.delete(); obs_op.delete();
    endtask

    task automatic test_timeout;
        bit ok;
        logic [7:0] e8, o8;
        logic [33:0] e34, o34;
        send_byte(8'h02);
        send_byte(8'h12);
        repeat (250) @(negedge clk);
        n_checks++;
        if ({bus.oBusy, bus.oOverrun} !== 2'b00)
            $display("FAIL timeout abort: got busy=%b overrun=%b want 0 0", bus.oBusy, bus.oOverrun);
        else n_pass++;
        n_checks++;
        if (obs_tx.size() != 0) $display("FAIL timeout no_response: got %0d bytes want 0", obs_tx.size());
        else n_pass++;
        send_packet(8'h02, 16'h0003, 16'h0004);
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("FAIL timeout idle_timeout: got busy want idle"); else n_pass++;
        n_checks++;
        if (obs_op.size() != exp_op.size())
            $display("FAIL timeout op_count: got %0d want %0d", obs_op.size(), exp_op.size());
        else n_pass++;
        while (exp_op.size() > 0 && obs_op.size() > 0) begin
            e34 = exp_op.pop_front(); o34 = obs_op.pop_front(); n_checks++;
            if (o34 !== e34) $display("FAIL timeout op_record: got %h want %h", o34, e34); else n_pass++;
        end
        n_checks++;
        if (obs_tx.size() != exp_tx.size())
            $display("FAIL timeout tx_count: got %0d want %0d", obs_tx.size(), exp_tx.size());
        else n_pass++;
        while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
            e8 = exp_tx.pop_front(); o8 = obs_tx.pop_front(); n_checks++;
            if (o8 !== e8) $display("FAIL timeout tx_byte: got %h want %h", o8, e8); else n_pass++;
        end
        exp_tx.delete(); obs_tx.delete(); exp_op.delete(); obs_op.delete();
    endtask

    task automatic test_overrun;
        bit ok;
        logic [7:0] e8, o8;
        send_packet(8'h02, 16'h0100, 16'h0203);
        @(negedge clk);
        n_checks++;
        if ({bus.oOpStart, bus.oOverrun} !== 2'b10)
            $display("FAIL overrun pre_state: got start=%b overrun=%b want 1 0", bus.oOpStart, bus.oOverrun);
        else n_pass++;
        @(negedge clk);
        bus.iRxByte = 8'h55;
        bus.iRxDone = 1'b1;
        @(negedge clk);
        bus.iRxDone = 1'b0;
        n_checks++;
        if (bus.oOverrun !== 1'b1) $display("FAIL overrun set: got %b want 1", bus.oOverrun);
        else n_pass++;
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("FAIL overrun idle_timeout: got busy want idle"); else n_pass++;
        n_checks++;
        if (obs_tx.size() != exp_tx.size())
            $display("FAIL overrun tx_count: got %0d want %0d", obs_tx.size(), exp_tx.size());
        else n_pass++;
        while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
            e8 = exp_tx.pop_front(); o8 = obs_tx.pop_front(); n_checks++;
            if (o8 !== e8) $display("FAIL overrun tx_byte: got %h want %h", o8, e8); else n_pass++;
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.oOverrun !== 1'b1) $display("FAIL overrun sticky: got %b want 1", bus.oOverrun);
        else n_pass++;
        exp_tx.delete(); obs_tx.delete(); exp_op.delete(); obs_op.delete();
    endtask

    task automatic test_back_to_back;
        bit ok1, ok2;
        logic [7:0] e8, o8;
        logic [33:0] e34, o34;
        send_packet(8'h01, 16'h0003, 16'h0004);
        wait_idle(ok1);
        send_packet(8'h02, 16'hFFFF, 16'hFFFF);
        wait_idle(ok2);
        n_checks++;
        if (!(ok1 && ok2)) $display("FAIL b2b idle_timeout: got busy want idle"); else n_pass++;
        n_checks++;
        if (obs_tx.size() != exp_tx.size())
            $display("FAIL b2b tx_count: got %0d want %0d", obs_tx.size(), exp_tx.size());
        else n_pass++;
        while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
            e8 = exp_tx.pop_front(); o8 = obs_tx.pop_front(); n_checks++;
            if (o8 !== e8) $display("FAIL b2b tx_byte: got %h want %h", o8, e8); else n_pass++;
        end
        while (exp_op.size() > 0 && obs_op.size() > 0) begin
            e34 = exp_op.pop_front(); o34 = obs_op.pop_front(); n_checks++;
            if (o34 !== e34) $display("FAIL b2b op_record: got %h want %h", o34, e34); else n_pass++;
        end
        exp_tx.delete(); obs_tx.delete(); exp_op.delete(); obs_op.delete();
    endtask

    task automatic test_reset_mid_tx;
        bit ok;
        int k;
        logic [7:0] e8, o8;
        send_packet(8'h00, 16'h1234, 16'h0011);
        k = 0;
        while (obs_tx.size() < 2 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (obs_tx.size() < 2) $display("FAIL rstmid reach_tx: got %0d bytes want 2", obs_tx.size());
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.oTxStart, bus.oTxByte, bus.oOpStart, bus.oOpCode, bus.oOperandA,
             bus.oOperandB, bus.oBusy, bus.oOverrun} !== 46'h0)
            $display("FAIL rstmid outputs: got %h want 0", {bus.oTxStart, bus.oTxByte,
                     bus.oOpStart, bus.oOpCode, bus.oOperandA, bus.oOperandB, bus.oBusy, bus.oOverrun});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        exp_tx.delete(); obs_tx.delete(); exp_op.delete(); obs_op.delete();
        send_packet(8'h02, 16'h0003, 16'h0005);
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("FAIL rstmid idle_timeout: got busy want idle"); else n_pass++;
        n_checks++;
        if (obs_tx.size() != exp_tx.size())
            $display("FAIL rstmid tx_count: got %0d want %0d", obs_tx.size(), exp_tx.size());
        else n_pass++;
        while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
            e8 = exp_tx.pop_front(); o8 = obs_tx.pop_front(); n_checks++;
            if (o8 !== e8) $display("FAIL rstmid tx_byte: got %h want %h", o8, e8); else n_pass++;
        end
        exp_tx.delete(); obs_tx.delete(); exp_op.delete(); obs_op.delete();
    endtask

    task automatic test_protocol;
        n_checks++;
        if ({op_consec, tx_consec} !== 64'h0)
            $display("FAIL protocol consecutive_pulses: got op=%0d tx=%0d want 0 0", op_consec, tx_consec);
        else n_pass++;
        n_checks++;
        if (hold_viol !== 0) $display("FAIL protocol tx_byte_hold: got %0d want 0", hold_viol);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_div_zero();
        test_bad_opcode();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_mid_tx();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
